// File: rtl/spm_prod_collector.sv
// Serial-to-parallel product collector for a bit-serial multiplier.
// Gathers 2*WIDTH LSB-first product bits and presents them with a valid/ready handshake.
module spm_prod_collector #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               p,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] prod,
    output logic               prod_valid,
    output logic               busy,
    output logic               overrun
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(PW);
    localparam logic [CW-1:0] LastBit = CW'(PW - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StHold} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   sr_q, sr_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic [PW-1:0]   shifted;
    logic            valid_q, valid_d;
    logic            ovr_q, ovr_d;

    // LSB-first bits enter at the top so bit 0 ends at index 0 after PW shifts.
    assign shifted = {p, sr_q[PW-1:1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        prod_d  = prod_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StCollect;
                    cnt_d   = '0;
                    sr_d    = '0;
                end
            end
            StCollect: begin
                sr_d  = shifted;
                cnt_d = cnt_q + 1'b1;
                if (start) begin
                    ovr_d = 1'b1;
                end
                if (cnt_q == LastBit) begin
                    prod_d  = shifted;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (start) begin
                        state_d = StCollect;
                        cnt_d   = '0;
                        sr_d    = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (start) begin
                    ovr_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sr_q    <= '0;
            prod_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            prod_q  <= prod_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign prod       = prod_q;
    assign prod_valid = valid_q;
    assign busy       = (state_q == StCollect);
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_spm_prod_collector.sv
// Directed and randomized bench for spm_prod_collector (WIDTH=4 and WIDTH=32 instances).
module tb_spm_prod_collector;

    logic clk;
    logic rst;

    logic       start4, p4, rdy4;
    logic [7:0] prod4;
    logic       valid4, busy4, ovr4;

    logic        start32, p32, rdy32;
    logic [63:0] prod32;
    logic        valid32, busy32, ovr32;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  q4[$];
    logic [63:0] q32[$];

    logic        hold_m;
    logic        ovr_m;
    logic        acc;
    logic [31:0] op_a, op_b;
    logic [63:0] pr;
    logic [7:0]  e_bits;

    spm_prod_collector #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .start     (start4),
        .p         (p4),
        .out_ready (rdy4),
        .prod      (prod4),
        .prod_valid(valid4),
        .busy      (busy4),
        .overrun   (ovr4)
    );

    spm_prod_collector #(.WIDTH(32)) dut32 (
        .clk       (clk),
        .rst       (rst),
        .start     (start32),
        .p         (p32),
        .out_ready (rdy32),
        .prod      (prod32),
        .prod_valid(valid32),
        .busy      (busy32),
        .overrun   (ovr32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a WIDTH=4 collection and feed its 8 bits; optionally re-pulse start at edge restart_at.
    task automatic run4(input logic [7:0] prodv, input int restart_at);
        q4.push_back(prodv);
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        chk("busy_after_start", busy4, 1);
        for (int k = 0; k < 8; k++) begin
            p4 = prodv[k];
            if (k + 1 == restart_at) start4 = 1'b1;
            step();
            start4 = 1'b0;
            if (k < 7) chk("busy_collect", busy4, 1);
            if (k + 1 == restart_at) chk("ovr_collect", ovr4, 1);
        end
        p4 = 1'b0;
        chk("valid_done", valid4, 1);
        chk("busy_done", busy4, 0);
        chk("prod_done", prod4, q4.pop_front());
    endtask

    // One clock of the WIDTH=32 run; the consumer side is checked against the scoreboard.
    task automatic tick32();
        if (hold_m && rdy32) begin
            chk("w32_valid_hs", valid32, 1);
            chk("w32_prod", prod32, q32.pop_front());
            hold_m = 1'b0;
        end
        step();
        rdy32 = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        rst = 1'b1;
        start4 = 1'b0; p4 = 1'b0; rdy4 = 1'b0;
        start32 = 1'b0; p32 = 1'b0; rdy32 = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_prod", prod4, 0);
        chk("rst_valid", valid4, 0);
        chk("rst_busy", busy4, 0);
        chk("rst_ovr", ovr4, 0);

        // 3*5 with consumer always ready: valid for exactly one cycle
        rdy4 = 1'b1;
        run4(8'h0F, -1);
        step();
        chk("t1_valid_clear", valid4, 0);
        chk("t1_prod_hold", prod4, 8'h0F);

        // 7*7 with consumer stalled for 5 cycles
        rdy4 = 1'b0;
        run4(8'h31, -1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_valid_stall", valid4, 1);
            chk("t2_prod_stall", prod4, 8'h31);
        end
        rdy4 = 1'b1;
        step();
        chk("t2_valid_accept", valid4, 0);
        chk("t2_busy_accept", busy4, 0);

        // start during COLLECT is dropped and flags overrun
        run4(8'h31, 3);
        step();
        chk("t3_ovr_sticky", ovr4, 1);

        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t3_rst_ovr", ovr4, 0);

        // start coincident with handshake in HOLD is accepted
        rdy4 = 1'b0;
        run4(8'h0F, -1);
        e_bits = 8'hE1;
        q4.push_back(e_bits);
        start4 = 1'b1;
        rdy4 = 1'b1;
        step();
        start4 = 1'b0;
        rdy4 = 1'b0;
        chk("t4_valid_clear", valid4, 0);
        chk("t4_busy", busy4, 1);
        chk("t4_prod_kept", prod4, 8'h0F);
        for (int k = 0; k < 8; k++) begin
            p4 = e_bits[k];
            step();
        end
        p4 = 1'b0;
        chk("t4_valid", valid4, 1);
        chk("t4_prod", prod4, q4.pop_front());
        chk("t4_ovr", ovr4, 0);

        // start in HOLD without handshake is dropped
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        chk("t4_hold_ovr", ovr4, 1);
        chk("t4_hold_valid", valid4, 1);
        chk("t4_hold_busy", busy4, 0);
        chk("t4_hold_prod", prod4, 8'hE1);
        rdy4 = 1'b1;
        step();
        chk("t4_hold_accept", valid4, 0);

        // reset mid-collection, reset also overrides start/out_ready
        rdy4 = 1'b0;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        p4 = 1'b1;
        for (int k = 0; k < 3; k++) step();
        rst = 1'b1;
        start4 = 1'b1;
        rdy4 = 1'b1;
        step();
        rst = 1'b0;
        start4 = 1'b0;
        rdy4 = 1'b0;
        p4 = 1'b0;
        chk("t5_rst_prod", prod4, 0);
        chk("t5_rst_valid", valid4, 0);
        chk("t5_rst_busy", busy4, 0);
        chk("t5_rst_ovr", ovr4, 0);
        step();
        run4(8'h06, -1);
        chk("t5_ovr", ovr4, 0);
        rdy4 = 1'b1;
        step();

        // WIDTH=32: back-to-back random products with random consumer stalls
        hold_m = 1'b0;
        ovr_m = 1'b0;
        rdy32 = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            op_a = $urandom;
            op_b = $urandom;
            pr = {32'b0, op_a} * {32'b0, op_b};
            if ($urandom_range(0, 7) == 0) tick32();
            acc = !hold_m || rdy32;
            if (acc) q32.push_back(pr);
            else ovr_m = 1'b1;
            start32 = 1'b1;
            tick32();
            start32 = 1'b0;
            for (int k = 0; k < 64; k++) begin
                p32 = pr[k];
                tick32();
            end
            p32 = 1'b0;
            if (acc) hold_m = 1'b1;
            chk("w32_valid_done", valid32, acc);
            chk("w32_ovr", ovr32, ovr_m);
        end
        for (int i = 0; i < 20 && hold_m; i++) begin
            rdy32 = 1'b1;
            tick32();
        end
        chk("w32_drained_valid", valid32, 0);
        chk("w32_sb_empty", q32.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
